// File: rtl/mmu09_pkg.sv
// Shared definitions for the MMU09 serial console: register map, status/control
// bit positions and the serializer/deserializer state encodings.
package mmu09_pkg;

    localparam logic REG_STAT = 1'b0;
    localparam logic REG_DATA = 1'b1;

    localparam int ST_RDRF   = 0;
    localparam int ST_TDRE   = 1;
    localparam int ST_TXIDLE = 2;
    localparam int ST_FE     = 4;
    localparam int ST_OVR    = 5;
    localparam int ST_IRQ    = 7;

    localparam int CR_RXIE  = 0;
    localparam int CR_TXIE  = 1;
    localparam int CR_SWRST = 7;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is dropped even if
// a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/acia_uart.sv
// 6850-style console UART: status/control and data registers, TX FIFO feeding an
// 8N1 serializer, single-byte RX holding register and a registered active-low IRQ.
module acia_uart
    import mmu09_pkg::*;
#(
    parameter int CLKDIV     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       i_eclk,
    input  logic       i_reset_n,
    input  logic       i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic       i_rd_n,
    input  logic       i_wr_n,
    input  logic       i_rxd,
    output logic       o_txd,
    output logic       o_irq_n
);
    localparam int CW = $clog2(CLKDIV);
    localparam int NW = $clog2(FIFO_DEPTH) + 1;

    logic          swrst, ctrl_wr, push, data_rd;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [NW-1:0] fifo_count;

    assign swrst   = !i_wr_n && (i_addr == REG_STAT) && i_data[CR_SWRST];
    assign ctrl_wr = !i_wr_n && (i_addr == REG_STAT) && !i_data[CR_SWRST];
    assign push    = !i_wr_n && (i_addr == REG_DATA);
    assign data_rd = !i_rd_n && (i_addr == REG_DATA);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(i_eclk), .rst_n(i_reset_n), .clr(swrst), .push(push), .pop(fifo_pop),
        .din(i_data), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
    );

    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_tick;

    assign tx_tick = (tx_cnt == CW'(CLKDIV - 1));

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_tick ? '0 : tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        fifo_pop   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_n = fifo_dout;
                    tx_state_n = TX_START;
                end
            end
            TX_START: if (tx_tick) begin
                tx_state_n = TX_DATA;
                tx_bit_n   = '0;
            end
            TX_DATA: if (tx_tick) begin
                tx_shift_n = {1'b0, tx_shift[7:1]};
                tx_bit_n   = tx_bit + 1'b1;
                if (tx_bit == 3'd7) tx_state_n = TX_STOP;
            end
            TX_STOP: if (tx_tick) begin
                // chain straight into the next frame so back-to-back bytes have no gap
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_n = fifo_dout;
                    tx_state_n = TX_START;
                end else begin
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_eclk or negedge i_reset_n) begin
        if (!i_reset_n || swrst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
        end
    end

    always_ff @(posedge i_eclk) tx_shift <= tx_shift_n;

    assign o_txd = (tx_state == TX_START) ? 1'b0 :
                   (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

    // Two-flop synchronizer; the third stage gives the falling-edge detector its history.
    logic rxd_p0, rxd_p1, rxd_p2;
    always_ff @(posedge i_eclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= i_rxd;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_tick, rx_half, rx_load, rx_ferr;

    assign rx_tick = (rx_cnt == CW'(CLKDIV - 1));
    assign rx_half = (rx_cnt == CW'(CLKDIV / 2 - 1));

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_tick ? '0 : rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_load    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rxd_p2 && !rxd_p1) rx_state_n = RX_START;
            end
            RX_START: if (rx_half) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rxd_p1 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_n = {rxd_p1, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 1'b1;
                if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
            RX_STOP: if (rx_tick) begin
                rx_state_n = RX_IDLE;
                rx_load    = rxd_p1;
                rx_ferr    = !rxd_p1;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_eclk or negedge i_reset_n) begin
        if (!i_reset_n || swrst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
        end
    end

    always_ff @(posedge i_eclk) rx_shift <= rx_shift_n;

    logic       rdrf, fe, ovr, rxie, txie, irq_n;
    logic [7:0] rx_data;

    always_ff @(posedge i_eclk or negedge i_reset_n) begin
        if (!i_reset_n || swrst) begin
            rdrf    <= 1'b0;
            fe      <= 1'b0;
            ovr     <= 1'b0;
            rxie    <= 1'b0;
            txie    <= 1'b0;
            rx_data <= 8'h00;
            irq_n   <= 1'b1;
        end else begin
            if (ctrl_wr) begin
                rxie <= i_data[CR_RXIE];
                txie <= i_data[CR_TXIE];
            end
            if (data_rd) begin
                rdrf <= 1'b0;
                fe   <= 1'b0;
                ovr  <= 1'b0;
            end
            // a read on the completing edge frees the holder, so the new byte is not an overrun
            if (rx_load) begin
                if (rdrf && !data_rd) begin
                    ovr <= 1'b1;
                end else begin
                    rx_data <= rx_shift;
                    rdrf    <= 1'b1;
                end
            end
            if (rx_ferr) fe <= 1'b1;
            irq_n <= !((rxie && (rdrf || ovr || fe)) || (txie && fifo_empty));
        end
    end

    assign o_irq_n = irq_n;

    logic [7:0] status;
    always_comb begin
        status            = '0;
        status[ST_RDRF]   = rdrf;
        status[ST_TDRE]   = !fifo_full;
        status[ST_TXIDLE] = (fifo_count == '0) && (tx_state == TX_IDLE);
        status[ST_FE]     = fe;
        status[ST_OVR]    = ovr;
        status[ST_IRQ]    = !irq_n;
    end

    assign o_data = (i_addr == REG_DATA) ? rx_data : status;

endmodule

// File: tb/tb_acia_uart.sv
// Self-checking bench for acia_uart: directed RX table, hand-timed corner cases and
// randomized TX/RX traffic checked against a frame-level reference model.
module tb_acia_uart;
    localparam int CLKDIV = 16;
    localparam int DEPTH  = 16;
    localparam int FRAME  = 10 * CLKDIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       addr = 1'b0;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       txd;
    logic       irq_n;

    acia_uart #(.CLKDIV(CLKDIV), .FIFO_DEPTH(DEPTH)) dut (
        .i_eclk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_data(wdata), .o_data(rdata),
        .i_rd_n(rd_n), .i_wr_n(wr_n), .i_rxd(rxd), .o_txd(txd), .o_irq_n(irq_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int falls = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         t;
    } txf_t;
    txf_t txq[$];

    // Line-level decoder of o_txd: find start bit, sample mid-bit.
    initial begin : tx_mon
        logic prev;
        txf_t f;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && txd === 1'b0) begin
                f.t = cyc;
                repeat (CLKDIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKDIV) @(negedge clk);
                    f.b[i] = txd;
                end
                repeat (CLKDIV) @(negedge clk);
                f.stop = txd;
                txq.push_back(f);
            end
            prev = txd;
        end
    end

    initial begin : fall_cnt
        logic p;
        p = 1'b1;
        forever begin
            @(negedge clk);
            if (p === 1'b1 && txd === 1'b0) falls++;
            p = txd;
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
    endtask

    task automatic bus_rd(input logic a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rd_n = 1'b0;
        #1 d = rdata;
        @(negedge clk);
        rd_n = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CLKDIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CLKDIV) @(negedge clk);
        end
        rxd = stop;
        repeat (CLKDIV) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_txq(input int n, input int budget);
        int k;
        k = 0;
        while (txq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("tx_frame_count", txq.size(), n);
    endtask

    task automatic check_tx(input logic [7:0] exp_b[$]);
        for (int i = 0; i < exp_b.size() && i < txq.size(); i++) begin
            check("tx_byte", txq[i].b, exp_b[i]);
            check("tx_stop", txq[i].stop, 1'b1);
            if (i > 0) check("tx_gap", txq[i].t - txq[i-1].t, FRAME);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       do_read;
        logic [7:0] exp_st;
        logic [7:0] exp_rd;
        logic [7:0] exp_st2;
    } rxv_t;

    initial begin : main
        rxv_t       tbl[6];
        logic [7:0] st, d, old;
        logic [7:0] exp_b[$];
        logic [7:0] m_hold;
        logic       m_rdrf, m_fe, m_ovr, stop;
        int         f0, n;

        tbl[0] = '{8'hA3, 1'b1, 1'b1, 8'h07, 8'hA3, 8'h06};
        tbl[1] = '{8'h5C, 1'b1, 1'b0, 8'h07, 8'h00, 8'h00};
        tbl[2] = '{8'h11, 1'b1, 1'b0, 8'h27, 8'h00, 8'h00};
        tbl[3] = '{8'h22, 1'b0, 1'b1, 8'h37, 8'h5C, 8'h06};
        tbl[4] = '{8'h80, 1'b0, 1'b0, 8'h16, 8'h00, 8'h00};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 8'h17, 8'hFF, 8'h06};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_txd", txd, 1'b1);
        check("reset_irq_n", irq_n, 1'b1);
        bus_rd(1'b0, st);
        check("reset_status", st, 8'h06);
        bus_rd(1'b1, d);
        check("reset_rxdata", d, 8'h00);

        // single byte 0x55: start bit appears one edge after the write edge
        bus_wr(1'b1, 8'h55);
        check("tx55_before_pop", txd, 1'b1);
        @(negedge clk);
        check("tx55_start_first", txd, 1'b0);
        repeat (15) @(negedge clk);
        check("tx55_start_last", txd, 1'b0);
        @(negedge clk);
        check("tx55_bit0", txd, 1'b1);
        repeat (141) @(negedge clk);
        bus_rd(1'b0, st);
        check("tx55_busy_status", st, 8'h02);
        bus_rd(1'b0, st);
        check("tx55_idle_status", st, 8'h06);
        wait_txq(1, 100);
        exp_b = '{8'h55};
        check_tx(exp_b);
        txq.delete();

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].b, tbl[i].stop);
            bus_rd(1'b0, st);
            check("rx_tbl_status", st, tbl[i].exp_st);
            if (tbl[i].do_read) begin
                bus_rd(1'b1, d);
                check("rx_tbl_data", d, tbl[i].exp_rd);
                bus_rd(1'b0, st);
                check("rx_tbl_status_after_read", st, tbl[i].exp_st2);
            end
        end

        @(negedge clk);
        rxd = 1'b0;
        repeat (7) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        bus_rd(1'b0, st);
        check("rx_glitch_status", st, 8'h06);

        // data read lands on the stop-sample edge of the next frame
        send_frame(8'h3C, 1'b1);
        bus_rd(1'b0, st);
        check("rx_same_edge_pre", st, 8'h07);
        fork
            send_frame(8'hC5, 1'b1);
            begin
                @(negedge clk);
                repeat (154) @(negedge clk);
                addr = 1'b1; rd_n = 1'b0;
                #1 old = rdata;
                @(negedge clk);
                rd_n = 1'b1;
            end
        join
        check("rx_same_edge_old", old, 8'h3C);
        bus_rd(1'b0, st);
        check("rx_same_edge_status", st, 8'h07);
        bus_rd(1'b1, d);
        check("rx_same_edge_new", d, 8'hC5);

        bus_wr(1'b0, 8'h03);
        check("irq_registered_delay", irq_n, 1'b1);
        @(negedge clk);
        check("irq_txie_empty", irq_n, 1'b0);
        bus_rd(1'b0, st);
        check("irq_status_bit", st, 8'h86);
        bus_wr(1'b0, 8'h01);
        check("irq_hold_one_cycle", irq_n, 1'b0);
        @(negedge clk);
        check("irq_txie_off", irq_n, 1'b1);
        send_frame(8'h9A, 1'b1);
        check("irq_rx_byte", irq_n, 1'b0);
        bus_rd(1'b1, d);
        check("irq_rx_data", d, 8'h9A);
        bus_rd(1'b0, st);
        check("irq_after_read", irq_n, 1'b1);
        check("irq_after_read_status", st, 8'h06);

        bus_wr(1'b0, 8'h03);
        for (int i = 0; i < 5; i++) bus_wr(1'b1, 8'(8'h30 + i));
        repeat (40) @(negedge clk);
        f0 = falls;
        bus_wr(1'b0, 8'h80);
        check("swrst_txd", txd, 1'b1);
        bus_rd(1'b0, st);
        check("swrst_status", st, 8'h06);
        repeat (3) @(negedge clk);
        check("swrst_irq_ctrl_cleared", irq_n, 1'b1);
        repeat (400) @(negedge clk);
        check("swrst_no_more_tx", falls, f0);
        txq.delete();

        bus_wr(1'b0, 8'h02);
        for (int i = 0; i < 5; i++) bus_wr(1'b1, 8'(8'h40 + i));
        repeat (40) @(negedge clk);
        f0 = falls;
        #3;
        rst_n = 1'b0;
        addr  = 1'b0;
        #1;
        check("areset_txd", txd, 1'b1);
        check("areset_status", rdata, 8'h06);
        check("areset_irq_n", irq_n, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        check("areset_no_more_tx", falls, f0);
        check("areset_irq_ctrl_cleared", irq_n, 1'b1);
        txq.delete();

        // 17 writes while a frame is in flight: 16 fill the FIFO, the last is dropped
        exp_b = '{8'hE1};
        bus_wr(1'b1, 8'hE1);
        repeat (5) @(negedge clk);
        for (int i = 1; i <= 17; i++) begin
            bus_wr(1'b1, 8'(i * 13 + 1));
            if (i <= DEPTH) exp_b.push_back(8'(i * 13 + 1));
            if (i == 15) begin
                bus_rd(1'b0, st);
                check("fifo_tdre_15", st[1], 1'b1);
            end
            if (i == 16) begin
                bus_rd(1'b0, st);
                check("fifo_tdre_16", st[1], 1'b0);
            end
        end
        wait_txq(17, 17 * FRAME + 400);
        check_tx(exp_b);
        repeat (300) @(negedge clk);
        check("fifo_drop_17th", txq.size(), 17);
        txq.delete();

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, DEPTH);
            exp_b.delete();
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                exp_b.push_back(d);
                bus_wr(1'b1, d);
            end
            wait_txq(n, n * FRAME + 400);
            check_tx(exp_b);
            repeat (20) @(negedge clk);
            txq.delete();
        end

        bus_wr(1'b0, 8'h80);
        m_hold = 8'h00; m_rdrf = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
        for (int it = 0; it < 30; it++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, stop);
            repeat ($urandom_range(0, 10)) @(negedge clk);
            if (stop) begin
                if (m_rdrf) m_ovr = 1'b1;
                else begin
                    m_hold = d;
                    m_rdrf = 1'b1;
                end
            end else begin
                m_fe = 1'b1;
            end
            bus_rd(1'b0, st);
            check("rx_rand_status", st, {2'b00, m_ovr, m_fe, 1'b0, 1'b1, 1'b1, m_rdrf});
            if ($urandom_range(0, 1) == 1) begin
                bus_rd(1'b1, d);
                check("rx_rand_data", d, m_hold);
                m_rdrf = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
